mmcm_drp_responder: RTL

- Synthesizable DRP target that behaves like the MMCM_ADV/PLL_ADV DRP port plus lock output.
- Used as the far end for our DRP reconfiguration master in simulation and in on-board loopback builds without a real MMCM.
- Holds a 128x16 register file, answers reads and writes with a configurable drdy latency, and models locked behaviour around rst_mmcm.
- Provides a backdoor observation port and protocol-error flag for checkers.

---
 rtl/mmcm_drp_responder_pkg.sv | 17 +
 rtl/mmcm_drp_responder_if.sv | 30 +++
 rtl/mmcm_drp_responder_lock.sv | 28 ++
 rtl/mmcm_drp_responder.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mmcm_drp_responder_pkg.sv
// Shared DRP definitions for the MMCM DRP responder, the DRP master and the bench.
package mmcm_drp_pkg;

  localparam int unsigned DRP_ADDR_W = 7;
  localparam int unsigned DRP_DATA_W = 16;
  localparam int unsigned DRP_DEPTH  = 128;

  typedef logic [DRP_ADDR_W-1:0] drp_addr_t;
  typedef logic [DRP_DATA_W-1:0] drp_data_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } drp_resp_state_t;

endpackage

// File: rtl/mmcm_drp_responder_if.sv
// DRP bus between a reconfiguration master and the MMCM DRP port.
interface mmcm_drp_responder_if;
  import mmcm_drp_pkg::*;

  logic      den;
  logic      dwe;
  drp_addr_t daddr;
  drp_data_t din;
  drp_data_t dout;
  logic      drdy;

  modport master (
    output den,
    output dwe,
    output daddr,
    output din,
    input  dout,
    input  drdy
  );

  modport slave (
    input  den,
    input  dwe,
    input  daddr,
    input  din,
    output dout,
    output drdy
  );

endinterface

// File: rtl/mmcm_drp_responder_lock.sv
// Lock model: locked rises after rst_mmcm has been low for LOCK_CYCLES edges.
module mmcm_lock_model #(
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic rst_mmcm,
  output logic locked
);

  localparam logic [16:0] LOCK_TGT = 17'(LOCK_CYCLES);

  logic [16:0] lock_cnt;

  // Count edges with rst_mmcm low; lock on the edge the count reaches LOCK_CYCLES.
  always_ff @(posedge clk) begin
    if (reset || rst_mmcm) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (!locked) begin
      lock_cnt <= lock_cnt + 17'd1;
      if (lock_cnt + 17'd1 == LOCK_TGT) begin
        locked <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmcm_drp_responder.sv
// DRP target emulating the MMCM_ADV/PLL_ADV DRP port: 128x16 register file,
// fixed drdy latency, lock model, backdoor observation and protocol-error flag.
module mmcm_drp_responder
  import mmcm_drp_pkg::*;
#(
  parameter int unsigned DRDY_LATENCY = 4,
  parameter int unsigned LOCK_CYCLES  = 64,
  parameter logic [15:0] INIT_VAL     = 16'h0000,
  parameter bit          DEN_HOLD     = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  mmcm_drp_responder_if.slave         drp,
  input  logic                        rst_mmcm,
  output logic                        locked,
  input  drp_addr_t                   obs_addr,
  output drp_data_t                   obs_data,
  output logic [15:0]                 wr_count,
  output logic                        proto_err
);

  localparam logic [3:0] LAT_LOAD = 4'(DRDY_LATENCY - 1);

  drp_resp_state_t state, state_nxt;
  logic            accept;
  logic            err_set;
  logic [3:0]      lat_cnt;
  drp_addr_t       cap_addr;
  logic            cap_we;
  drp_data_t       cap_din;
  drp_data_t       dout_q;
  drp_data_t       mem [DRP_DEPTH];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, request acceptance and protocol-error detection.
  // BUSY leaves on lat_cnt==1: the decrement in that cycle takes the counter
  // to zero, so the loaded DRDY_LATENCY-1 yields drdy exactly DRDY_LATENCY
  // cycles after acceptance.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (drp.den) begin
          accept    = 1'b1;
          state_nxt = (DRDY_LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (lat_cnt == 4'd1) begin
          state_nxt = RESP;
        end
        err_set = drp.den && !DEN_HOLD;
      end
      RESP: begin
        state_nxt = IDLE;
        err_set   = drp.den && !DEN_HOLD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture registers, latency counter, held read data, write count, error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_addr  <= '0;
      cap_we    <= 1'b0;
      cap_din   <= '0;
      lat_cnt   <= '0;
      dout_q    <= '0;
      wr_count  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (accept) begin
        cap_addr <= drp.daddr;
        cap_we   <= drp.dwe;
        cap_din  <= drp.din;
        lat_cnt  <= LAT_LOAD;
      end else if (state == BUSY) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (err_set) begin
        proto_err <= 1'b1;
      end
      if (state == RESP) begin
        dout_q <= mem[cap_addr];
        if (cap_we) begin
          wr_count <= wr_count + 16'd1;
        end
      end
    end
  end

  // Register file; every entry returns to INIT_VAL on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DRP_DEPTH; i++) begin
        mem[i] <= INIT_VAL;
      end
    end else if (state == RESP && cap_we) begin
      mem[cap_addr] <= cap_din;
    end
  end

  // DRP response: pre-write data during RESP, last response held otherwise.
  always_comb begin
    drp.drdy = 1'b0;
    drp.dout = dout_q;
    if (state == RESP) begin
      drp.drdy = 1'b1;
      drp.dout = mem[cap_addr];
    end
  end

  // Backdoor observation, free of side effects.
  always_comb begin
    obs_data = mem[obs_addr];
  end

  mmcm_lock_model #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock (
    .clk      (clk),
    .reset    (reset),
    .rst_mmcm (rst_mmcm),
    .locked   (locked)
  );

endmodule
